// File: rtl/load_store_ctrl.sv
// ============================================================================
// Module   : load_store_ctrl
// Purpose  : MEM-stage load/store sequencer. Checks the access for alignment
//            and legal size, drives one word-wide bus transaction, waits for
//            the acknowledge and returns an extended load result. The result
//            comes with a one-cycle completion pulse.
// Optional : BUS_TIMEOUT_EN - when defined, the bus request is aborted after
//            TIMEOUT_CYCLES unacknowledged REQ cycles and TimeoutErr is
//            reported. When undefined, REQ waits forever, no counter is
//            built and TimeoutErr is tied low.
// Ports    : clk, reset (async, active low)
//            Start, IsLoad, Mode[2:0], Addr[31:0], WData[31:0] - access request
//            Busy (stall), Done, RData[31:0], AddrErr, TimeoutErr  - response
//            MemReq, MemWe, MemAddr[31:0], MemBE[3:0], MemWData[31:0],
//            MemAck, MemRData[31:0]                                - bus
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic        IsLoad,
    input  logic [2:0]  Mode,
    input  logic [31:0] Addr,
    input  logic [31:0] WData,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] RData,
    output logic        AddrErr,
    output logic        TimeoutErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemBE,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] M_WORD = 3'b000;
    localparam logic [2:0] M_B    = 3'b001;
    localparam logic [2:0] M_BU   = 3'b010;
    localparam logic [2:0] M_H    = 3'b011;
    localparam logic [2:0] M_HU   = 3'b100;

    state_t      state;
    logic        ld_q;
    logic [2:0]  mode_q;
    logic [1:0]  lo_q;

    logic        access_err;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] shifted;
    logic [31:0] load_result;

    assign Busy = (state != S_IDLE);

    // Legality check, byte-enable and store-data replication for the incoming
    // request; only consumed in IDLE when Start is high.
    always_comb begin
        access_err = 1'b0;
        be_next    = 4'b1111;
        wdata_next = WData;
        case (Mode)
            M_WORD: begin
                access_err = (Addr[1:0] != 2'b00);
            end
            M_B, M_BU: begin
                // Unsigned variants exist only for loads.
                access_err = (Mode == M_BU) && !IsLoad;
                be_next    = 4'b0001 << Addr[1:0];
                wdata_next = {4{WData[7:0]}};
            end
            M_H, M_HU: begin
                access_err = Addr[0] || ((Mode == M_HU) && !IsLoad);
                be_next    = 4'b0011 << Addr[1:0];
                wdata_next = {2{WData[15:0]}};
            end
            default: begin
                access_err = 1'b1;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend by the latched mode.
    assign shifted = MemRData >> {lo_q, 3'b000};

    always_comb begin
        case (mode_q)
            M_B:     load_result = {{24{shifted[7]}}, shifted[7:0]};
            M_BU:    load_result = {24'd0, shifted[7:0]};
            M_H:     load_result = {{16{shifted[15]}}, shifted[15:0]};
            M_HU:    load_result = {16'd0, shifted[15:0]};
            default: load_result = shifted;
        endcase
    end

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
`else
    assign TimeoutErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ld_q       <= 1'b0;
            mode_q     <= 3'b000;
            lo_q       <= 2'b00;
            Done       <= 1'b0;
            RData      <= 32'd0;
            AddrErr    <= 1'b0;
            MemReq     <= 1'b0;
            MemWe      <= 1'b0;
            MemAddr    <= 32'd0;
            MemBE      <= 4'd0;
            MemWData   <= 32'd0;
`ifdef BUS_TIMEOUT_EN
            TimeoutErr <= 1'b0;
            to_cnt     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        if (access_err) begin
                            state   <= S_DONE;
                            Done    <= 1'b1;
                            AddrErr <= 1'b1;
                            RData   <= 32'd0;
                        end else begin
                            state    <= S_REQ;
                            ld_q     <= IsLoad;
                            mode_q   <= Mode;
                            lo_q     <= Addr[1:0];
                            MemReq   <= 1'b1;
                            MemWe    <= ~IsLoad;
                            MemAddr  <= {Addr[31:2], 2'b00};
                            MemBE    <= be_next;
                            MemWData <= wdata_next;
`ifdef BUS_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                        end
                    end
                end
                S_REQ: begin
                    // Acknowledge has priority over an expiring timeout.
                    if (MemAck) begin
                        state  <= S_DONE;
                        MemReq <= 1'b0;
                        MemWe  <= 1'b0;
                        Done   <= 1'b1;
                        RData  <= ld_q ? load_result : 32'd0;
`ifdef BUS_TIMEOUT_EN
                    end else if (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state      <= S_DONE;
                        MemReq     <= 1'b0;
                        MemWe      <= 1'b0;
                        Done       <= 1'b1;
                        TimeoutErr <= 1'b1;
                        RData      <= 32'd0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    // DONE: single pulse, flags are only meaningful with Done.
                    state   <= S_IDLE;
                    Done    <= 1'b0;
                    AddrErr <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                    TimeoutErr <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_ctrl.sv
// ============================================================================
// Module   : tb_load_store_ctrl
// Purpose  : Scoreboard bench for load_store_ctrl. Stimulus pushes expected
//            bus requests and completion results into queues; monitors pop
//            and compare when MemReq rises or Done pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_ctrl;

    logic        clk;
    logic        reset;
    logic        Start;
    logic        IsLoad;
    logic [2:0]  Mode;
    logic [31:0] Addr;
    logic [31:0] WData;
    logic        Busy;
    logic        Done;
    logic [31:0] RData;
    logic        AddrErr;
    logic        TimeoutErr;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemBE;
    logic [31:0] MemWData;
    logic        MemAck;
    logic [31:0] MemRData;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        ae;
        logic        te;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic        chk_wd;
    } bus_t;

    done_t done_q[$];
    bus_t  bus_q[$];

    load_store_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .Start      (Start),
        .IsLoad     (IsLoad),
        .Mode       (Mode),
        .Addr       (Addr),
        .WData      (WData),
        .Busy       (Busy),
        .Done       (Done),
        .RData      (RData),
        .AddrErr    (AddrErr),
        .TimeoutErr (TimeoutErr),
        .MemReq     (MemReq),
        .MemWe      (MemWe),
        .MemAddr    (MemAddr),
        .MemBE      (MemBE),
        .MemWData   (MemWData),
        .MemAck     (MemAck),
        .MemRData   (MemRData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    logic req_d  = 1'b0;
    logic done_d = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            if (Done) begin
                check("done_one_cycle", {31'd0, done_d}, 32'd0);
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t e;
                    e = done_q.pop_front();
                    check("rdata", RData, e.rd);
                    check("addr_err", {31'd0, AddrErr}, {31'd0, e.ae});
                    check("timeout_err", {31'd0, TimeoutErr}, {31'd0, e.te});
                end
            end
            if (MemReq && !req_d) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_memreq", 32'd1, 32'd0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check("mem_addr", MemAddr, b.addr);
                    check("mem_be", {28'd0, MemBE}, {28'd0, b.be});
                    check("mem_we", {31'd0, MemWe}, {31'd0, b.we});
                    if (b.chk_wd) check("mem_wdata", MemWData, b.wd);
                end
            end
        end
        req_d  <= MemReq;
        done_d <= Done;
    end

    // ---------------- stimulus ----------------
    // waits < 0 means never acknowledge (timeout expected).
    task automatic xfer(input logic ld, input logic [2:0] md, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] bus_rd, input int waits,
                        input logic err, input logic [31:0] exp_rd, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd, input logic exp_to);
        done_t d;
        bus_t  b;
        d.rd = exp_rd; d.ae = err; d.te = exp_to;
        done_q.push_back(d);
        if (!err) begin
            b.addr = {a[31:2], 2'b00}; b.be = exp_be; b.we = ~ld;
            b.wd = exp_wd; b.chk_wd = ~ld;
            bus_q.push_back(b);
        end
        @(posedge clk); #1;
        Start = 1'b1; IsLoad = ld; Mode = md; Addr = a; WData = wd;
        @(posedge clk); #1;
        Start = 1'b0;
        if (err) begin
            check("err_done_t1", {31'd0, Done}, 32'd1);
            check("err_no_memreq", {31'd0, MemReq}, 32'd0);
        end else begin
            check("memreq_t1", {31'd0, MemReq}, 32'd1);
            if (waits < 0) begin
                int n = 1;
                while (MemReq && n < 100) begin
                    @(posedge clk); #1;
                    if (MemReq) n++;
                end
                check("timeout_req_cycles", n, 32'd16);
            end else begin
                for (int i = 0; i < waits; i++) begin
                    @(posedge clk); #1;
                    check("memreq_held", {31'd0, MemReq}, 32'd1);
                end
                MemAck = 1'b1; MemRData = bus_rd;
                @(posedge clk); #1;
                MemAck = 1'b0; MemRData = 32'h5A5A_5A5A;
            end
            check("done_after_ack", {31'd0, Done}, 32'd1);
            check("memreq_dropped", {31'd0, MemReq}, 32'd0);
        end
        @(posedge clk); #1;
        check("done_cleared", {31'd0, Done}, 32'd0);
        check("idle_after", {31'd0, Busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b0; Start = 1'b0; IsLoad = 1'b0; Mode = 3'b000;
        Addr = 32'd0; WData = 32'd0; MemAck = 1'b0; MemRData = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_memreq", {31'd0, MemReq}, 32'd0);
        check("rst_rdata", RData, 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_membe", {28'd0, MemBE}, 32'd0);
        check("rst_memwdata", MemWData, 32'd0);
        reset = 1'b1;

        // lb at top byte, sign bit set, ack on first REQ cycle
        xfer(1'b1, 3'b001, 32'h0000_1003, 32'd0, 32'h80AA_5511, 0, 1'b0,
             32'hFFFF_FF80, 4'b1000, 32'd0, 1'b0);
        // sh upper half, 3 wait cycles
        xfer(1'b0, 3'b011, 32'h0000_2002, 32'h0000_BEEF, 32'hFFFF_FFFF, 3, 1'b0,
             32'd0, 4'b1100, 32'hBEEF_BEEF, 1'b0);
        // misaligned word load and reserved mode
        xfer(1'b1, 3'b000, 32'h0000_0006, 32'd0, 32'd0, 0, 1'b1,
             32'd0, 4'd0, 32'd0, 1'b0);
        xfer(1'b1, 3'b111, 32'h0000_0000, 32'd0, 32'd0, 0, 1'b1,
             32'd0, 4'd0, 32'd0, 1'b0);
        // store with unsigned-only modes, misaligned halfword
        xfer(1'b0, 3'b010, 32'h0000_0000, 32'h11, 32'd0, 0, 1'b1,
             32'd0, 4'd0, 32'd0, 1'b0);
        xfer(1'b0, 3'b100, 32'h0000_0000, 32'h11, 32'd0, 0, 1'b1,
             32'd0, 4'd0, 32'd0, 1'b0);
        xfer(1'b1, 3'b011, 32'h0000_0001, 32'd0, 32'd0, 0, 1'b1,
             32'd0, 4'd0, 32'd0, 1'b0);
        // lbu lane 1, lh lane 0 negative, lw
        xfer(1'b1, 3'b010, 32'h0000_0001, 32'd0, 32'h1234_5678, 1, 1'b0,
             32'h0000_0056, 4'b0010, 32'd0, 1'b0);
        xfer(1'b1, 3'b011, 32'h0000_0000, 32'd0, 32'h0000_F00D, 0, 1'b0,
             32'hFFFF_F00D, 4'b0011, 32'd0, 1'b0);
        xfer(1'b1, 3'b000, 32'h0000_0008, 32'd0, 32'hCAFE_F00D, 2, 1'b0,
             32'hCAFE_F00D, 4'b1111, 32'd0, 1'b0);
        // sw and sb
        xfer(1'b0, 3'b000, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 0, 1'b0,
             32'd0, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        xfer(1'b0, 3'b001, 32'h0000_0005, 32'h0000_00A5, 32'd0, 0, 1'b0,
             32'd0, 4'b0010, 32'hA5A5_A5A5, 1'b0);

        // stray acknowledge in IDLE must do nothing
        @(posedge clk); #1;
        MemAck = 1'b1;
        @(posedge clk); #1;
        MemAck = 1'b0;
        check("idle_ack_busy", {31'd0, Busy}, 32'd0);
        check("idle_ack_done", {31'd0, Done}, 32'd0);

        // reset in the middle of REQ: request dropped asynchronously, no Done
        begin
            bus_t b;
            b.addr = 32'h0000_0020; b.be = 4'b1111; b.we = 1'b0;
            b.wd = 32'd0; b.chk_wd = 1'b0;
            bus_q.push_back(b);
        end
        @(posedge clk); #1;
        Start = 1'b1; IsLoad = 1'b1; Mode = 3'b000; Addr = 32'h0000_0020;
        @(posedge clk); #1;
        Start = 1'b0;
        check("pre_reset_memreq", {31'd0, MemReq}, 32'd1);
        @(negedge clk); #1;
        reset = 1'b0;
        #1;
        check("async_reset_memreq", {31'd0, MemReq}, 32'd0);
        check("async_reset_busy", {31'd0, Busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        // lhu after recovery
        xfer(1'b1, 3'b100, 32'h0000_0002, 32'd0, 32'h9ABC_1234, 0, 1'b0,
             32'h0000_9ABC, 4'b1100, 32'd0, 1'b0);

`ifdef BUS_TIMEOUT_EN
        // no ack: abort after 16 REQ cycles
        xfer(1'b1, 3'b000, 32'h0000_0040, 32'd0, 32'd0, -1, 1'b0,
             32'd0, 4'b1111, 32'd0, 1'b1);
        // ack on the 16th REQ cycle wins over the timeout
        xfer(1'b1, 3'b000, 32'h0000_0044, 32'd0, 32'h0BAD_CAFE, 15, 1'b0,
             32'h0BAD_CAFE, 4'b1111, 32'd0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("done_q_empty", done_q.size(), 32'd0);
        check("bus_q_empty", bus_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/load_store_ctrl.md
LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the REQ-state cycles allowed before abort (used only under BUS_TIMEOUT_EN).
REQ-002 clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 Start  in  1  SHALL be the pipeline MEM-stage access request, sampled in IDLE only.
REQ-005 IsLoad  in  1  SHALL select the access type: 1 = load, 0 = store.
REQ-006 Mode  in  3  SHALL select the access size: 000 word, 001 lb/sb, 010 lbu, 011 lh/sh, 100 lhu; all other codes are reserved.
REQ-007 Addr  in  32  SHALL be the byte address.
REQ-008 WData  in  32  SHALL be the store data, right-justified.
REQ-009 Busy  out  1  SHALL be the pipeline stall, high whenever state is not IDLE.
REQ-010 Done  out  1  SHALL be a one-cycle completion pulse.
REQ-011 RData  out  32  SHALL carry the extended load result.
REQ-012 AddrErr  out  1  SHALL flag a misaligned or reserved access, valid with Done.
REQ-013 TimeoutErr  out  1  SHALL flag a bus timeout, valid with Done.
REQ-014 MemReq/MemWe  out  1/1  SHALL be the bus request and bus write enable.
REQ-015 MemAddr  out  32  SHALL be the word-aligned bus address.
REQ-016 MemBE  out  4  SHALL be the bus byte enables.
REQ-017 MemWData  out  32  SHALL be the bus write data.
REQ-018 MemAck  in  1  SHALL be the bus acknowledge.
REQ-019 MemRData  in  32  SHALL be the bus read data, valid while MemAck is high.

Function
REQ-020 The FSM SHALL have three states: IDLE, REQ and DONE; all outputs are registered except Busy.
REQ-021 In IDLE with Start=1, the block SHALL check the access: half-word modes require Addr[0]=0; word mode requires Addr[1:0]=00; reserved codes and store codes 010/100 are errors.
REQ-022 On an error, the block SHALL enter DONE with AddrErr=1, RData=0 and no MemReq.
REQ-023 On a legal access, the block SHALL latch IsLoad, Mode and Addr[1:0] and enter REQ.
REQ-024 In REQ, the block SHALL assert MemReq=1, MemWe=~IsLoad and MemAddr={Addr[31:2],00}, all held stable until MemAck=1 is sampled.
REQ-025 MemBE SHALL be: byte modes 0001<<Addr[1:0]; half-word modes 0011<<Addr[1:0]; word mode 1111.
REQ-026 MemWData SHALL be: sb {4{WData[7:0]}}; sh {2{WData[15:0]}}; sw WData.
REQ-027 MemAck=1 in REQ SHALL cause a move to DONE with MemReq deasserted the next cycle; for a load, MemRData is captured on that edge.
REQ-028 Load result SHALL be formed as follows: shift MemRData right by 8*Addr[1:0]; lb sign-extends bit 7; lbu zero-extends 8 bits; lh sign-extends bit 15; lhu zero-extends 16 bits; lw passes the word through.
REQ-029 In DONE, the block SHALL assert Done=1 for exactly one cycle and return to IDLE; RData SHALL be the result for loads and 0 for stores.
REQ-030 RData SHALL hold its value until the next Done.
REQ-031 Minimum latency SHALL be: Start at cycle t, MemReq at t+1, MemAck at t+1, Done at t+2.
REQ-032 Start SHALL be ignored while Busy=1; MemAck SHALL be ignored in IDLE and DONE.
REQ-033 A Start on the cycle DONE→IDLE SHALL not be accepted; it is accepted on the next cycle if still held.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, clear all registered outputs to 0 (MemReq, MemWe, MemAddr, MemBE, MemWData, Done, RData, AddrErr, TimeoutErr) and clear the timeout counter.
REQ-035 A reset during REQ SHALL abandon the transaction without emitting Done.

Configuration
REQ-036 With BUS_TIMEOUT_EN defined, a counter SHALL count REQ cycles; on reaching TIMEOUT_CYCLES without MemAck, the block drops MemReq and enters DONE with TimeoutErr=1 and RData=0.
REQ-037 If MemAck and the timeout occur in the same cycle, MemAck SHALL win.
REQ-038 Without BUS_TIMEOUT_EN, REQ SHALL wait indefinitely, no counter is built and TimeoutErr is tied to 0.

Verification
REQ-039 Load lb, Addr=0x1003, MemRData=0x80AA5511, ack on first REQ cycle -> MemBE=1000, MemAddr=0x1000, RData=0xFFFFFF80, Done at t+2.
REQ-040 Store sh, Addr=0x2002, WData=0x0000BEEF -> MemWe=1, MemBE=1100, MemWData=0xBEEFBEEF; with ack after 3 wait cycles -> Done 1 cycle, RData=0.
REQ-041 Load lw, Addr=0x0006 -> no MemReq, Done with AddrErr=1 at t+1; Mode=111 produces the same response.
REQ-042 reset=0 mid-REQ -> MemReq=0 asynchronously, no Done; after release, a new lhu from Addr=0x0002 with MemRData=0x9ABC1234 -> RData=0x00009ABC.
REQ-043 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16, MemAck never asserted -> MemReq high 16 cycles, then Done with TimeoutErr=1; an ack on cycle 16 instead yields normal completion.
